// File: rtl/spram_pkg.sv
// Shared types and constants for the SPRAM controller slice.
package spram_pkg;

    localparam int ROW_AW  = 14;
    localparam int LANE_AW = 2;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} acc_sz_e;
    typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} pwr_st_e;

    // Reserved size, or a half/word access not on its natural boundary.
    function automatic logic access_err(input acc_sz_e sz, input logic [LANE_AW-1:0] lane);
        logic err;
        case (sz)
            SZ_H:    err = lane[0];
            SZ_W:    err = (lane != '0);
            SZ_RSV:  err = 1'b1;
            default: err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/sp256k.sv
// Behavioural stand-in for the iCE40UP SP256K 16K x 16 single-port RAM.
// Leave this file out when building against the vendor primitive library.
module SP256K (
    input  logic [13:0] AD,
    input  logic [15:0] DI,
    input  logic [3:0]  MASKWE,
    input  logic        WE,
    input  logic        CS,
    input  logic        CK,
    input  logic        STDBY,
    input  logic        SLEEP,
    input  logic        PWROFF_N,
    output logic [15:0] DO
);

    logic [15:0] mem [16384];

    // Output register only updates on a read; MASKWE bit i enables nibble i.
    always_ff @(posedge CK) begin
        if (CS && !SLEEP && !STDBY && PWROFF_N) begin
            if (WE) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (MASKWE[i]) mem[AD][4*i +: 4] <= DI[4*i +: 4];
                end
            end else begin
                DO <= mem[AD];
            end
        end
    end

endmodule

// File: rtl/spram_bank.sv
// One 16K x 32 bank built from a pair of SP256K: low half-word lanes 0/1, high lanes 2/3.
module spram_bank
    import spram_pkg::*;
(
    input  logic              clk,
    input  logic              cs,
    input  logic              we,
    input  logic              sleep,
    input  logic [3:0]        mask,
    input  logic [ROW_AW-1:0] row,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [3:0] mask_lo;
    logic [3:0] mask_hi;

    // Each byte lane owns two MASKWE nibbles of its primitive.
    assign mask_lo = {mask[1], mask[1], mask[0], mask[0]};
    assign mask_hi = {mask[3], mask[3], mask[2], mask[2]};

    SP256K u_lo (
        .AD       (row),
        .DI       (wdata[15:0]),
        .MASKWE   (mask_lo),
        .WE       (we),
        .CS       (cs),
        .CK       (clk),
        .STDBY    (1'b0),
        .SLEEP    (sleep),
        .PWROFF_N (1'b1),
        .DO       (rdata[15:0])
    );

    SP256K u_hi (
        .AD       (row),
        .DI       (wdata[31:16]),
        .MASKWE   (mask_hi),
        .WE       (we),
        .CS       (cs),
        .CK       (clk),
        .STDBY    (1'b0),
        .SLEEP    (sleep),
        .PWROFF_N (1'b1),
        .DO       (rdata[31:16])
    );

endmodule

// File: rtl/spram_ctl.sv
// Byte-addressed 32-bit SPRAM port over NBANK banks: sized access, 1-cycle
// response, misalignment errors and an idle-driven SLEEP/WAKE power FSM.
module spram_ctl
    import spram_pkg::*;
#(
    parameter int NBANK      = 2,
    parameter int IDLE_SLEEP = 256,
    parameter int WAKE_CYC   = 3,
    parameter int BAW        = 16 + $clog2(NBANK)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic           req_we,
    input  logic [1:0]     req_sz,
    input  logic           req_sx,
    input  logic [BAW-1:0] req_addr,
    input  logic [31:0]    req_wdata,
    output logic           rsp_valid,
    output logic [31:0]    rsp_rdata,
    output logic           rsp_err,
    input  logic           sleep_en,
    output logic           asleep
);

    localparam int BKW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int ICW = (IDLE_SLEEP > 0) ? $clog2(IDLE_SLEEP + 1) : 1;
    localparam int WCW = $clog2(WAKE_CYC + 1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(IDLE_SLEEP);
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);

    pwr_st_e            state_q, state_d;
    logic [ICW-1:0]     idle_q, idle_d;
    logic [WCW-1:0]     wake_q, wake_d;

    acc_sz_e            sz;
    logic [LANE_AW-1:0] lane;
    logic [ROW_AW-1:0]  row;
    logic [BKW-1:0]     bank;
    logic               req_err;
    logic               accept;
    logic               ram_sleep;
    logic [3:0]         wmask;
    logic [31:0]        wdata_rep;

    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic               rsp_we_q;
    logic [BKW-1:0]     bank_q;
    logic [LANE_AW-1:0] lane_q;
    acc_sz_e            sz_q;
    logic               sx_q;

    logic [31:0]        bank_rdata [NBANK];
    logic [31:0]        sel_rdata;
    logic [31:0]        shifted;
    logic [31:0]        ext_rdata;

    assign sz   = acc_sz_e'(req_sz);
    assign lane = req_addr[LANE_AW-1:0];
    assign row  = req_addr[15:2];

    generate
        if (NBANK > 1) begin : g_bank_sel
            assign bank = req_addr[BAW-1:16];
        end else begin : g_bank_one
            assign bank = '0;
        end
    endgenerate

    assign req_err   = access_err(sz, lane);
    assign req_ready = rst_n && (state_q == ACTIVE);
    assign accept    = req_valid && req_ready;
    assign ram_sleep = (state_q == SLEEP);
    assign asleep    = ram_sleep;

    always_comb begin
        wmask     = 4'hF;
        wdata_rep = req_wdata;
        case (sz)
            SZ_B: begin
                wmask     = 4'b0001 << lane;
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                wmask     = 4'b0011 << lane;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    genvar b;
    generate
        for (b = 0; b < NBANK; b++) begin : g_bank
            logic cs_b;
            assign cs_b = accept && !req_err && (bank == BKW'(b));

            spram_bank u_bank (
                .clk   (clk),
                .cs    (cs_b),
                .we    (req_we),
                .sleep (ram_sleep),
                .mask  (wmask),
                .row   (row),
                .wdata (wdata_rep),
                .rdata (bank_rdata[b])
            );
        end
    endgenerate

    // Read controls are captured at accept so the mux follows the address
    // that produced the primitive's registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
            bank_q      <= '0;
            lane_q      <= '0;
            sz_q        <= SZ_W;
            sx_q        <= 1'b0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_err_q <= req_err;
                rsp_we_q  <= req_we;
                bank_q    <= bank;
                lane_q    <= lane;
                sz_q      <= sz;
                sx_q      <= req_sx;
            end
        end
    end

    assign sel_rdata = bank_rdata[bank_q];
    assign shifted   = sel_rdata >> {lane_q, 3'b000};

    always_comb begin
        ext_rdata = sel_rdata;
        case (sz_q)
            SZ_B:    ext_rdata = {{24{sx_q & shifted[7]}}, shifted[7:0]};
            SZ_H:    ext_rdata = {{16{sx_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q && rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && !rsp_err_q && !rsp_we_q) ? ext_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACTIVE;
            idle_q  <= '0;
            wake_q  <= '0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            wake_q  <= wake_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        wake_d  = wake_q;
        case (state_q)
            ACTIVE: begin
                if (accept) begin
                    idle_d = '0;
                end else begin
                    if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
                    // Sleep on the idle cycle that brings the count to threshold.
                    if (sleep_en && (IDLE_SLEEP != 0) && (idle_d == IDLE_MAX)) state_d = SLEEP;
                end
            end
            SLEEP: begin
                if (req_valid || !sleep_en) begin
                    state_d = WAKE;
                    wake_d  = '0;
                end
            end
            WAKE: begin
                if (wake_q == WAKE_LAST) begin
                    state_d = ACTIVE;
                    idle_d  = '0;
                end else begin
                    wake_d = wake_q + 1'b1;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

endmodule

// File: doc/spram_ctl.md
Name: spram_ctl

Overview:
Parametrised single-port SPRAM controller: NBANK banks, each a 16K x 32 pair of SP256K primitives, giving one byte-addressed 32-bit memory port.
- Adds byte/half/word access with sign/zero extension, a valid/ready request handshake with a fixed-latency response, and misalignment detection.
- Adds an idle-driven SLEEP/WAKE power FSM.
- The read-side bank select is registered so the output mux matches the address that produced the data.
- Serves as the data/dictionary memory port of the eForth core.

Parameters:
NBANK, 2, number of 16K x 32 banks; power of two, 1..8.
IDLE_SLEEP, 256, consecutive idle cycles before auto-sleep; 0 disables auto-sleep.
WAKE_CYC, 3, cycles spent in WAKE with SLEEP deasserted before accepting requests; must be >= 1.
BAW, 16+$clog2(NBANK), derived byte-address width; do not override.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller accepts the request this cycle.
req_we  in  1  0 read, 1 write.
req_sz  in  2  0 byte, 1 half, 2 word, 3 reserved.
req_sx  in  1  reads only: 1 sign-extend, 0 zero-extend.
req_addr  in  BAW  byte address.
req_wdata  in  32  write data, right-justified.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  32  read result; 0 when rsp_valid=0, for writes, or on error.
rsp_err  out  1  accepted request was misaligned or reserved; valid with rsp_valid.
sleep_en  in  1  permits auto-sleep.
asleep  out  1  1 while in SLEEP.

Behaviour:
- Reset (async assert, sync release) forces:
  - state ACTIVE, idle counter 0, wake counter 0;
  - rsp_valid 0, rsp_err 0, rsp_rdata 0, asleep 0;
  - req_ready 0 while rst_n=0.
  - An in-flight response is discarded. A write clocked in before reset asserted stays committed.
- Handshake and latency:
  - A request is accepted when req_valid && req_ready. req_ready = (state==ACTIVE).
  - Every accepted request produces exactly one rsp_valid pulse in the next cycle (latency 1). There is no response backpressure.
  - Back-to-back accepts are allowed, one per cycle.
- Address decode:
  - bank = addr[BAW-1:16], row = addr[15:2], lane = addr[1:0].
  - CS is asserted only for the selected bank, and only on an accepted, non-error request.
- Error conditions: sz=3; sz=1 with addr[0]=1; sz=2 with addr[1:0]!=0.
  - On error, no RAM access occurs. The response has rsp_err=1 and rdata=0.
- Write lanes (little-endian, lane 0 = bits 7:0):
  - byte: wdata[7:0] replicated x4, lane mask 1<<lane.
  - half: wdata[15:0] replicated x2, lane mask 2'b11<<lane.
  - word: data as given, mask 4'hF.
  - Lane k enables MASKWE nibbles 2k and 2k+1 of the owning SP256K.
- Read path:
  - bank, lane, sz and sx are registered at accept.
  - The registered bank selects the DO pair combinationally in the response cycle.
  - The selected byte or half is shifted down by 8*lane, then sign- or zero-extended to 32 bits. Word reads are passed through unchanged.
- Power FSM:
  - ACTIVE -> SLEEP when sleep_en=1, IDLE_SLEEP!=0 and the idle counter reaches IDLE_SLEEP. The counter increments on cycles with no accept, clears on an accept, and saturates at IDLE_SLEEP.
  - SLEEP: SP256K SLEEP=1, asleep=1, req_ready=0; contents are retained.
  - SLEEP -> WAKE when req_valid=1 or sleep_en=0. SLEEP pins drop on entry to WAKE.
  - WAKE -> ACTIVE after WAKE_CYC cycles; idle counter cleared. Changes on sleep_en during WAKE are ignored.
- Simultaneous events: if a request arrives in the cycle the idle threshold would be reached, the accept wins, the counter clears and there is no sleep.
- Fixed pins: STDBY=0, PWROFF_N=1 always.

Decomposition:
- Package spram_pkg holds:
  - typedef enum acc_sz_e {SZ_B, SZ_H, SZ_W, SZ_RSV};
  - typedef enum pwr_st_e {ACTIVE, SLEEP, WAKE};
  - constants ROW_AW=14, LANE_AW=2.
- Sub-module spram_bank: two SP256K forming 16K x 32, with ports clk, cs, we, sleep, 4-bit lane mask, row, wdata, rdata.
- spram_ctl instantiates NBANK copies of spram_bank in a generate loop.

Test Plan:
1. Word write 0xDEADBEEF @0x0010, read word @0x0010 next cycle -> rsp_valid one cycle after accept, rdata 0xDEADBEEF, err 0.
2. Then byte write 0x80 @0x0013:
   - byte read @0x0013 sx=1 -> 0xFFFFFF80; sx=0 -> 0x00000080.
   - word read @0x0010 -> 0x80ADBEEF.
   - half read @0x0012 sx=1 -> 0xFFFF80AD.
3. NBANK=2: write 0x11111111 @0xFFFC and 0x22222222 @0x10000, then back-to-back reads of both -> 0x11111111 then 0x22222222 on consecutive cycles, no cross-bank corruption.
4. Half read @0x0011, word write @0x0012, sz=3 @0x0 -> each gives rsp_err=1, rdata 0; a word re-read @0x0010 is unchanged.
5. IDLE_SLEEP=8, WAKE_CYC=3, sleep_en=1:
   - asleep rises after 8 idle cycles;
   - req_valid held -> req_ready returns exactly 3 cycles after leaving SLEEP;
   - previously written data reads back intact.
6. Assert rst_n=0 in the cycle after a read is accepted -> rsp_valid stays 0, req_ready 0 during reset; after release, state is ACTIVE with asleep 0 and earlier writes are retained.
